// File: rtl/led_counter.sv
// ---------------------------------------------------------------------------
// led_counter
//   Free-running up counter for the LED display. A prescaler divides the board
//   clock so that the count advances once every TICK_DIV enabled cycles. The
//   count wraps from MAX_COUNT to 0. Each step produces a one-cycle tick pulse,
//   and each wrap also produces a one-cycle wrap pulse.
//
// Parameters
//   WIDTH      count width in bits
//   TICK_DIV   enabled clk cycles per count step (>= 1)
//   MAX_COUNT  last value before wrapping to 0 (1 .. 2^WIDTH-1)
//
// Ports
//   clk        board clock; all logic is on posedge
//   rst        asynchronous active-high reset
//   en         count enable, synchronous to clk; low pauses the prescaler
//   count_out  registered count value
//   tick       one-cycle pulse on the edge where count_out changes
//   wrap       one-cycle pulse on the edge where count_out goes MAX_COUNT->0
// ---------------------------------------------------------------------------
module led_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned TICK_DIV  = 125000000,
  parameter int unsigned MAX_COUNT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count_out,
  output logic             tick,
  output logic             wrap
);

  // A divide-by-1 or divide-by-2 prescaler still needs one bit of state.
  localparam int unsigned PW = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);

  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MAX_COUNT);

  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_wrap;
  logic             w_step;

  // With TICK_DIV == 1, PRE_LAST is 0, so r_pre stays 0 and every enabled
  // cycle is a step.
  assign w_step = en && (r_pre == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (en) begin
      if (w_step) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_tick <= 1'b1;
      if (r_count == CNT_LAST) begin
        r_count <= '0;
        r_wrap  <= 1'b1;
      end else begin
        r_count <= r_count + WIDTH'(1);
        r_wrap  <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign count_out = r_count;
  assign tick      = r_tick;
  assign wrap      = r_wrap;

endmodule
